mlu_mul_seq: RTL and testbench
==============================

// Module: mlu_mul_seq
// PURPOSE
//  Owns the shared 32-bit mlu and sequences it to compute unsigned 32x32->64 products by shift-and-add.
//  One MLU_ADD per iteration, with the mlu carry-out captured as product bit.
//  When idle it passes the core's combinational mlu request (EXT_*) straight through.
//  Sits between the core datapath and the mlu; the core stalls on BUSY.
// PARAMETERS
//  WIDTH      32   operand width; must equal mlu width (32)
//  CNT_W      6    iteration counter width; must be >= clog2(WIDTH)+1
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  N_RST      in   1      async active-low reset
//  EXT_A      in   32     core operand A (bypass path)
//  EXT_B      in   32     core operand B (bypass path)
//  EXT_OP     in   3      core mlu opcode (common::MLU_*)
//  EXT_C_IN   in   1      core carry-in
//  REQ_VALID  in   1      multiply request valid
//  REQ_READY  out  1      sequencer can accept request
//  REQ_MCAND  in   32     multiplicand
//  REQ_MPLIER in   32     multiplier
//  ABORT      in   1      sync cancel of in-flight multiply, no response
//  RESP_VALID out  1      product valid
//  RESP_READY in   1      consumer accepts product
//  RESP_HI    out  32     product[63:32]
//  RESP_LO    out  32     product[31:0]
//  BUSY       out  1      sequencer owns mlu (state != IDLE)
//  MLU_A      out  32     to mlu A
//  MLU_B      out  32     to mlu B
//  MLU_OP     out  3      to mlu OP
//  MLU_C_IN   out  1      to mlu C_IN
//  MLU_OUT    in   32     from mlu OUT
//  MLU_C      in   1      from mlu C (carry-out)
// BEHAVIOUR
//  States: IDLE, ITER, DONE. Regs: acc_hi[31:0], acc_lo[31:0], mcand[31:0], cnt[CNT_W-1:0].
//  Reset (async, N_RST=0): state=IDLE, acc_hi/acc_lo/mcand/cnt=0; outputs REQ_READY=1 (once ABORT=0), RESP_VALID=0, BUSY=0.
//  MLU mux (combinational): IDLE -> MLU_{A,B,OP,C_IN}=EXT_{A,B,OP,C_IN}.
//  ITER -> MLU_A=acc_hi, MLU_B=acc_lo[0]?mcand:0, MLU_OP=common::MLU_ADD, MLU_C_IN=0.
//  DONE -> MLU_OP=common::MLU_NOP0, MLU_A=MLU_B=0, MLU_C_IN=0.
//  REQ_READY = (state==IDLE) && !ABORT. Accept on REQ_VALID&&REQ_READY at edge:
//   acc_hi<=0, acc_lo<=REQ_MPLIER, mcand<=REQ_MCAND, cnt<=0, state<=ITER.
//  ITER, each edge: acc_hi<={MLU_C,MLU_OUT[31:1]}, acc_lo<={MLU_OUT[0],acc_lo[31:1]}, cnt<=cnt+1.
//   When cnt==WIDTH-1 at the edge, state<=DONE. Exactly 32 ITER cycles.
//  Latency: accept edge t0; ITER during cycles t0..t31; RESP_VALID=1 after edge t32.
//  Every multiply takes 32 cycles; there is no early exit on a zero multiplier.
//  DONE: RESP_VALID=1, RESP_HI=acc_hi, RESP_LO=acc_lo, held stable until RESP_READY=1 at an edge, then state<=IDLE.
//  There is no same-cycle re-accept: the next request is accepted the cycle after the return to IDLE.
//  RESP_HI/RESP_LO are don't-care when RESP_VALID=0 (they reflect acc regs).
//  ABORT=1 at an edge in ITER or DONE: state<=IDLE, no RESP_VALID pulse, regs keep values.
//   ABORT in IDLE blocks acceptance (REQ_READY=0) that cycle.
//   ABORT and RESP_READY both high in DONE: treat as abort. Both paths return to IDLE.
//  REQ_VALID while BUSY: ignored (REQ_READY=0); requester holds.
//  N_RST low mid-operation: immediate return to IDLE, in-flight product lost, mlu back on bypass.
//  BUSY=(state!=IDLE); the core must not rely on EXT_* results while BUSY=1.
//  Overflow is impossible: the 64-bit product always fits in {acc_hi,acc_lo}.
//  The carry is taken only from MLU_C and never recomputed locally.
// TESTING
//  3 x 5 -> after 32 ITER cycles RESP_VALID=1, RESP_HI=0x00000000, RESP_LO=0x0000000F.
//  0xFFFFFFFF x 0xFFFFFFFF -> RESP_HI=0xFFFFFFFE, RESP_LO=0x00000001 (exercises MLU_C every iteration).
//  0x12345678 x 0 then 0 x 0x9ABCDEF0, RESP_READY low 5 cycles -> 0/0, RESP held stable, REQ_READY=0 until consumed.
//  ABORT in 10th ITER cycle, then request 7x6 -> no response for aborted op; second yields HI=0, LO=0x2A.
//  N_RST pulsed low mid-ITER -> BUSY=0, RESP_VALID=0 immediately; EXT_OP=MLU_XOR, A=0xF0F0F0F0, B=0xFFFFFFFF seen on MLU_* ports.
//  Random 1000 mul ops with random RESP_READY/REQ_VALID gaps vs A*B model; bypass equality checked on every IDLE cycle.

Source files
------------

// File: rtl/mlu_mul_seq.sv
// Shift-and-add unsigned WIDTHxWIDTH -> 2*WIDTH multiplier that borrows the shared mlu.
// While idle, the core's combinational mlu request passes straight through to the mlu.
module mlu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic [WIDTH-1:0] EXT_A,
  input  logic [WIDTH-1:0] EXT_B,
  input  logic [2:0]       EXT_OP,
  input  logic             EXT_C_IN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_MCAND,
  input  logic [WIDTH-1:0] REQ_MPLIER,
  input  logic             ABORT,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESP_HI,
  output logic [WIDTH-1:0] RESP_LO,
  output logic             BUSY,
  output logic [WIDTH-1:0] MLU_A,
  output logic [WIDTH-1:0] MLU_B,
  output logic [2:0]       MLU_OP,
  output logic             MLU_C_IN,
  input  logic [WIDTH-1:0] MLU_OUT,
  input  logic             MLU_C
);

  // Opcode encoding understood by the shared mlu
  localparam logic [2:0] MLU_NOP0 = 3'd0;
  localparam logic [2:0] MLU_ADD  = 3'd1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  assign REQ_READY  = (state == S_IDLE) && !ABORT;
  assign RESP_VALID = (state == S_DONE);
  assign BUSY       = (state != S_IDLE);
  assign RESP_HI    = acc_hi;
  assign RESP_LO    = acc_lo;

  always_comb begin
    MLU_A    = EXT_A;
    MLU_B    = EXT_B;
    MLU_OP   = EXT_OP;
    MLU_C_IN = EXT_C_IN;
    case (state)
      S_ITER: begin
        // Partial-product add: the multiplier's current LSB gates the multiplicand in
        MLU_A    = acc_hi;
        MLU_B    = acc_lo[0] ? mcand : '0;
        MLU_OP   = MLU_ADD;
        MLU_C_IN = 1'b0;
      end
      S_DONE: begin
        MLU_A    = '0;
        MLU_B    = '0;
        MLU_OP   = MLU_NOP0;
        MLU_C_IN = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state  <= S_IDLE;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID && !ABORT) begin
            acc_hi <= '0;
            acc_lo <= REQ_MPLIER;
            mcand  <= REQ_MCAND;
            cnt    <= '0;
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (ABORT) begin
            state <= S_IDLE;
          end else begin
            // Shift the sum right one place; the mlu carry becomes the new MSB
            acc_hi <= {MLU_C, MLU_OUT[WIDTH-1:1]};
            acc_lo <= {MLU_OUT[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST_ITER) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ABORT || RESP_READY) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlu_mul_seq.sv
// Self-checking bench for mlu_mul_seq: behavioural mlu plus a transaction-level model
// of the sequencer (product = a*b, fixed 32-edge latency), compared every cycle.
module tb_mlu_mul_seq;

  localparam int W = 32;
  localparam logic [2:0] MLU_NOP0 = 3'd0;
  localparam logic [2:0] MLU_ADD  = 3'd1;
  localparam logic [2:0] MLU_SUB  = 3'd2;
  localparam logic [2:0] MLU_AND  = 3'd3;
  localparam logic [2:0] MLU_OR   = 3'd4;
  localparam logic [2:0] MLU_XOR  = 3'd5;

  logic          CLK = 1'b0;
  logic          N_RST;
  logic [W-1:0]  EXT_A, EXT_B;
  logic [2:0]    EXT_OP;
  logic          EXT_C_IN;
  logic          REQ_VALID, REQ_READY;
  logic [W-1:0]  REQ_MCAND, REQ_MPLIER;
  logic          ABORT;
  logic          RESP_VALID, RESP_READY;
  logic [W-1:0]  RESP_HI, RESP_LO;
  logic          BUSY;
  logic [W-1:0]  MLU_A, MLU_B, MLU_OUT;
  logic [2:0]    MLU_OP;
  logic          MLU_C_IN, MLU_C;
  logic [W:0]    mlu_res;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  mlu_mul_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .N_RST(N_RST),
    .EXT_A(EXT_A), .EXT_B(EXT_B), .EXT_OP(EXT_OP), .EXT_C_IN(EXT_C_IN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_MCAND(REQ_MCAND), .REQ_MPLIER(REQ_MPLIER),
    .ABORT(ABORT),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_HI(RESP_HI), .RESP_LO(RESP_LO),
    .BUSY(BUSY),
    .MLU_A(MLU_A), .MLU_B(MLU_B), .MLU_OP(MLU_OP), .MLU_C_IN(MLU_C_IN),
    .MLU_OUT(MLU_OUT), .MLU_C(MLU_C)
  );

  // Behavioural shared mlu
  always_comb begin
    mlu_res = '0;
    case (MLU_OP)
      MLU_ADD: mlu_res = {1'b0, MLU_A} + {1'b0, MLU_B} + {{W{1'b0}}, MLU_C_IN};
      MLU_SUB: mlu_res = {1'b0, MLU_A} - {1'b0, MLU_B};
      MLU_AND: mlu_res = {1'b0, MLU_A & MLU_B};
      MLU_OR:  mlu_res = {1'b0, MLU_A | MLU_B};
      MLU_XOR: mlu_res = {1'b0, MLU_A ^ MLU_B};
      default: mlu_res = '0;
    endcase
  end
  assign MLU_OUT = mlu_res[W-1:0];
  assign MLU_C   = mlu_res[W];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Transaction-level reference: busy from accept until consumed/aborted,
  // product valid after exactly W further edges.
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int          m_done_cnt = 0;

  always @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (!m_busy) begin
      if (REQ_VALID && !ABORT) begin
        m_busy  <= 1'b1;
        m_valid <= 1'b0;
        m_left  <= W;
        m_a     <= REQ_MCAND;
        m_b     <= REQ_MPLIER;
        m_prod  <= 64'(REQ_MCAND) * 64'(REQ_MPLIER);
      end
    end else if (ABORT) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_valid) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (RESP_READY) begin
      m_busy     <= 1'b0;
      m_valid    <= 1'b0;
      m_done_cnt <= m_done_cnt + 1;
      $display("txn %0d: %h x %h = %h", m_done_cnt, m_a, m_b, m_prod);
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge CLK) begin
    chk("busy", 64'(BUSY), 64'(m_busy));
    chk("req_ready", 64'(REQ_READY), 64'(!m_busy && !ABORT));
    chk("resp_valid", 64'(RESP_VALID), 64'(m_valid));
    if (m_valid) begin
      chk("resp_product", {RESP_HI, RESP_LO}, m_prod);
      chk("mlu_done_op", 64'(MLU_OP), 64'(MLU_NOP0));
      chk("mlu_done_ab", {MLU_A, MLU_B}, 64'd0);
      chk("mlu_done_cin", 64'(MLU_C_IN), 64'd0);
    end else if (m_busy) begin
      chk("mlu_iter_op", 64'(MLU_OP), 64'(MLU_ADD));
      chk("mlu_iter_cin", 64'(MLU_C_IN), 64'd0);
    end else begin
      chk("bypass_ab", {MLU_A, MLU_B}, {EXT_A, EXT_B});
      chk("bypass_op", 64'(MLU_OP), 64'(EXT_OP));
      chk("bypass_cin", 64'(MLU_C_IN), 64'(EXT_C_IN));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input logic [63:0] exp, input string name);
    int g;
    int lat;
    REQ_MCAND = a; REQ_MPLIER = b; REQ_VALID = 1'b1; RESP_READY = 1'b0;
    g = 0;
    while (!REQ_READY && g < 100) begin tick(); g++; end
    chk({name, " accept"}, 64'(REQ_READY), 64'd1);
    tick();
    REQ_VALID = 1'b0;
    lat = 0;
    while (!RESP_VALID && lat < 100) begin tick(); lat++; end
    chk({name, " latency"}, 64'(lat), 64'd32);
    chk({name, " product"}, {RESP_HI, RESP_LO}, exp);
    repeat (hold) begin
      tick();
      chk({name, " held"}, {RESP_HI, RESP_LO}, exp);
      chk({name, " held valid"}, 64'(RESP_VALID), 64'd1);
      chk({name, " held ready"}, 64'(REQ_READY), 64'd0);
    end
    RESP_READY = 1'b1;
    tick();
    RESP_READY = 1'b0;
    chk({name, " idle after"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    int g;
    int cyc;
    int target;
    bit acc_prev;
    N_RST = 1'b0; ABORT = 1'b0; REQ_VALID = 1'b0; RESP_READY = 1'b0;
    REQ_MCAND = '0; REQ_MPLIER = '0;
    EXT_A = '0; EXT_B = '0; EXT_OP = MLU_NOP0; EXT_C_IN = 1'b0;
    #1;
    chk("reset req_ready", 64'(REQ_READY), 64'd1);
    chk("reset busy", 64'(BUSY), 64'd0);
    chk("reset resp_valid", 64'(RESP_VALID), 64'd0);
    tick(); tick();
    N_RST = 1'b1;
    tick();

    do_mul(32'd3, 32'd5, 0, 64'h0000_0000_0000_000F, "3x5");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, "ffxff");
    do_mul(32'h1234_5678, 32'd0, 5, 64'd0, "x_by_0");
    do_mul(32'd0, 32'h9ABC_DEF0, 5, 64'd0, "0_by_x");

    // Abort during the 10th ITER cycle
    REQ_MCAND = 32'hDEAD_BEEF; REQ_MPLIER = 32'h1234_5678; REQ_VALID = 1'b1;
    g = 0;
    while (!REQ_READY && g < 100) begin tick(); g++; end
    tick();
    REQ_VALID = 1'b0;
    repeat (9) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort busy", 64'(BUSY), 64'd0);
    chk("abort resp_valid", 64'(RESP_VALID), 64'd0);
    repeat (40) begin
      tick();
      chk("abort no resp", 64'(RESP_VALID), 64'd0);
    end
    do_mul(32'd7, 32'd6, 0, 64'h2A, "7x6");

    // Asynchronous reset mid-ITER
    EXT_A = 32'hF0F0_F0F0; EXT_B = 32'hFFFF_FFFF; EXT_OP = MLU_XOR; EXT_C_IN = 1'b0;
    REQ_MCAND = 32'hAAAA_5555; REQ_MPLIER = 32'h0F0F_1234; REQ_VALID = 1'b1;
    g = 0;
    while (!REQ_READY && g < 100) begin tick(); g++; end
    tick();
    REQ_VALID = 1'b0;
    repeat (10) tick();
    #1 N_RST = 1'b0;
    #1;
    chk("rst busy", 64'(BUSY), 64'd0);
    chk("rst resp_valid", 64'(RESP_VALID), 64'd0);
    chk("rst mlu_op", 64'(MLU_OP), 64'd5);
    chk("rst mlu_a", 64'(MLU_A), 64'hF0F0_F0F0);
    chk("rst mlu_b", 64'(MLU_B), 64'hFFFF_FFFF);
    tick();
    N_RST = 1'b1;
    tick();

    // Randomised traffic with gaps, backpressure and rare aborts
    target = m_done_cnt + 1000;
    cyc = 0;
    acc_prev = 1'b0;
    while (m_done_cnt < target && cyc < 70000) begin
      if (!REQ_VALID || acc_prev) begin
        REQ_VALID  = ($urandom_range(0, 3) != 0);
        REQ_MCAND  = rand_operand();
        REQ_MPLIER = rand_operand();
      end
      RESP_READY = $urandom_range(0, 1) == 1;
      ABORT      = ($urandom_range(0, 299) == 0);
      EXT_A      = $urandom;
      EXT_B      = $urandom;
      EXT_OP     = 3'($urandom_range(0, 7));
      EXT_C_IN   = $urandom_range(0, 1) == 1;
      acc_prev   = REQ_VALID && REQ_READY;
      tick();
      cyc++;
    end
    chk("random ops completed", 64'(m_done_cnt >= target), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
